// File: rtl/pulp_rf_checkpoint_log_pkg.sv
// rtl/pulp_rf_checkpoint_log_pkg.sv - shared types and defaults for the RF checkpoint log
package pulp_rf_checkpoint_log_pkg;

  localparam int unsigned RfAddrWidth       = 5;
  localparam int unsigned RfDataWidth       = 32;
  localparam int unsigned RfLogDefaultDepth = 16;

  typedef struct packed {
    logic [RfAddrWidth-1:0] addr;
    logic [RfDataWidth-1:0] data;
  } rf_log_entry_t;

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_REPLAY,
    REP_DONE
  } rep_state_e;

endpackage

// File: rtl/pulp_rf_checkpoint_log_ring.sv
// rtl/pulp_rf_checkpoint_log_ring.sv - per-core circular log of committed RF writes
module pulp_rf_checkpoint_log_ring #(
  parameter int unsigned Depth     = 16,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned PtrW     = $clog2(Depth),
  localparam int unsigned CntW     = PtrW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 ckpt,
  input  logic                 clear,
  input  logic [PtrW-1:0]      rd_idx,
  output logic [AddrWidth-1:0] rd_addr,
  output logic [DataWidth-1:0] rd_data,
  output logic [CntW-1:0]      count,
  output logic [PtrW-1:0]      oldest,
  output logic                 overflow
);

  logic [AddrWidth+DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]                wr_ptr;

  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr] <= {wr_addr, wr_data};
  end

  // A checkpoint in the same cycle as a write starts a new log holding just that write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PtrW'(1);
      if (ckpt) begin
        count    <= CntW'(1);
        overflow <= 1'b0;
      end else if (count == CntW'(Depth)) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CntW'(1);
      end
    end else if (ckpt) begin
      count    <= '0;
      overflow <= 1'b0;
    end
  end

  assign oldest             = wr_ptr - count[PtrW-1:0];
  assign {rd_addr, rd_data} = mem[rd_idx];

endmodule

// File: rtl/pulp_rf_checkpoint_log.sv
// rtl/pulp_rf_checkpoint_log.sv - multi-core RF write log with a shared oldest-first replay engine
module pulp_rf_checkpoint_log
  import pulp_rf_checkpoint_log_pkg::*;
#(
  parameter int unsigned NumCores  = 8,
  parameter int unsigned Depth     = RfLogDefaultDepth,
  parameter int unsigned AddrWidth = RfAddrWidth,
  parameter int unsigned DataWidth = RfDataWidth,
  localparam int unsigned CoreW    = (NumCores > 1) ? $clog2(NumCores) : 1,
  localparam int unsigned PtrW     = $clog2(Depth),
  localparam int unsigned CntW     = PtrW + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumCores-1:0]           wr_valid_i,
  input  logic [NumCores*AddrWidth-1:0] wr_addr_i,
  input  logic [NumCores*DataWidth-1:0] wr_data_i,
  input  logic [NumCores-1:0]           ckpt_i,
  input  logic [NumCores-1:0]           rec_req_i,
  output logic                          rep_valid_o,
  input  logic                          rep_ready_i,
  output logic [CoreW-1:0]              rep_core_o,
  output logic [AddrWidth-1:0]          rep_addr_o,
  output logic [DataWidth-1:0]          rep_data_o,
  output logic                          rec_busy_o,
  output logic [NumCores-1:0]           rec_done_o,
  output logic [NumCores-1:0]           overflow_o
);

  rep_state_e          state;
  logic [CoreW-1:0]    cur;
  logic [CoreW-1:0]    sel;
  logic [PtrW-1:0]     rd_ptr;
  logic [CntW-1:0]     rem;
  logic [NumCores-1:0] pending;
  logic [NumCores-1:0] cur_mask;
  logic [NumCores-1:0] active_mask;
  logic [NumCores-1:0] done_mask;

  logic [PtrW-1:0]      ring_oldest [NumCores];
  logic [CntW-1:0]      ring_count  [NumCores];
  logic [AddrWidth-1:0] ring_addr   [NumCores];
  logic [DataWidth-1:0] ring_data   [NumCores];

  assign cur_mask    = NumCores'(1) << cur;
  assign active_mask = (state != REP_IDLE) ? cur_mask : '0;
  assign done_mask   = (state == REP_DONE) ? cur_mask : '0;

  // The core being replayed is frozen so its log cannot shift under the read pointer.
  for (genvar k = 0; k < NumCores; k++) begin : g_ring
    pulp_rf_checkpoint_log_ring #(
      .Depth     (Depth),
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth)
    ) u_ring (
      .clk      (clk_i),
      .rst      (rst_i),
      .wr_en    (wr_valid_i[k] && !active_mask[k]),
      .wr_addr  (wr_addr_i[k*AddrWidth +: AddrWidth]),
      .wr_data  (wr_data_i[k*DataWidth +: DataWidth]),
      .ckpt     (ckpt_i[k] && !active_mask[k]),
      .clear    (done_mask[k]),
      .rd_idx   (rd_ptr),
      .rd_addr  (ring_addr[k]),
      .rd_data  (ring_data[k]),
      .count    (ring_count[k]),
      .oldest   (ring_oldest[k]),
      .overflow (overflow_o[k])
    );
  end

  always_comb begin
    sel = '0;
    for (int i = NumCores - 1; i >= 0; i--) begin
      if (pending[i]) sel = CoreW'(i);
    end
  end

  // Clearing in DONE wins over a re-request of the same core in that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= REP_IDLE;
      cur     <= '0;
      rd_ptr  <= '0;
      rem     <= '0;
      pending <= '0;
    end else begin
      pending <= (pending | rec_req_i) & ~done_mask;
      unique case (state)
        REP_IDLE: begin
          if (|pending) begin
            cur    <= sel;
            rd_ptr <= ring_oldest[sel];
            rem    <= ring_count[sel];
            state  <= (ring_count[sel] == '0) ? REP_DONE : REP_REPLAY;
          end
        end
        REP_REPLAY: begin
          if (rep_ready_i) begin
            rd_ptr <= rd_ptr + PtrW'(1);
            rem    <= rem - CntW'(1);
            if (rem == CntW'(1)) state <= REP_DONE;
          end
        end
        REP_DONE: state <= REP_IDLE;
        default:  state <= REP_IDLE;
      endcase
    end
  end

  assign rep_valid_o = (state == REP_REPLAY);
  assign rep_core_o  = cur;
  assign rep_addr_o  = rep_valid_o ? ring_addr[cur] : '0;
  assign rep_data_o  = rep_valid_o ? ring_data[cur] : '0;
  assign rec_busy_o  = (state != REP_IDLE);
  assign rec_done_o  = done_mask;

endmodule

// File: tb/tb_pulp_rf_checkpoint_log.sv
// tb/tb_pulp_rf_checkpoint_log.sv - directed self-checking bench for pulp_rf_checkpoint_log
module tb_pulp_rf_checkpoint_log;

  localparam int NC = 8;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NC-1:0]    wr_valid_i;
  logic [NC*AW-1:0] wr_addr_i;
  logic [NC*DW-1:0] wr_data_i;
  logic [NC-1:0]    ckpt_i;
  logic [NC-1:0]    rec_req_i;
  logic             rep_valid_o;
  logic             rep_ready_i;
  logic [2:0]       rep_core_o;
  logic [AW-1:0]    rep_addr_o;
  logic [DW-1:0]    rep_data_o;
  logic             rec_busy_o;
  logic [NC-1:0]    rec_done_o;
  logic [NC-1:0]    overflow_o;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] core5_q[$];

  always #5 clk_i = ~clk_i;

  pulp_rf_checkpoint_log #(
    .NumCores  (NC),
    .Depth     (16),
    .AddrWidth (AW),
    .DataWidth (DW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_valid_i  (wr_valid_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .ckpt_i      (ckpt_i),
    .rec_req_i   (rec_req_i),
    .rep_valid_o (rep_valid_o),
    .rep_ready_i (rep_ready_i),
    .rep_core_o  (rep_core_o),
    .rep_addr_o  (rep_addr_o),
    .rep_data_o  (rep_data_o),
    .rec_busy_o  (rec_busy_o),
    .rec_done_o  (rec_done_o),
    .overflow_o  (overflow_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic log_write(input int core, input int a, input int d, input bit ck);
    wr_valid_i[core]          = 1'b1;
    ckpt_i[core]              = ck;
    wr_addr_i[core*AW +: AW]  = AW'(a);
    wr_data_i[core*DW +: DW]  = DW'(d);
    tick();
    wr_valid_i[core] = 1'b0;
    ckpt_i[core]     = 1'b0;
  endtask

  task automatic request(input logic [NC-1:0] mask);
    rec_req_i = mask;
    tick();
    rec_req_i = '0;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_valid"},    64'(rep_valid_o), 64'(0));
    chk({tag, "_busy"},     64'(rec_busy_o),  64'(0));
    chk({tag, "_done"},     64'(rec_done_o),  64'(0));
    chk({tag, "_overflow"}, 64'(overflow_o),  64'(0));
    chk({tag, "_core"},     64'(rep_core_o),  64'(0));
    chk({tag, "_addr"},     64'(rep_addr_o),  64'(0));
    chk({tag, "_data"},     64'(rep_data_o),  64'(0));
  endtask

  // Consumes exp_q from the restore port; disturb pokes writes at core 4 (active) and core 5.
  task automatic drain(input int core, input bit random_ready, input bit disturb);
    int idx;
    int cyc;
    int n;
    bit hs;
    idx = 0;
    cyc = 0;
    n   = exp_q.size();
    while (idx < n && cyc < 400) begin
      hs = 1'b0;
      if (!random_ready && idx > 0) chk("stream_valid", 64'(rep_valid_o), 64'(1));
      if (rep_valid_o) begin
        chk("rep_core", 64'(rep_core_o), 64'(core));
        chk("rep_entry", 64'({rep_addr_o, rep_data_o}), 64'(exp_q[idx]));
        rep_ready_i = random_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        hs = rep_ready_i;
        if (disturb) begin
          wr_valid_i[4]         = 1'b1;
          wr_addr_i[4*AW +: AW] = AW'(31);
          wr_data_i[4*DW +: DW] = 32'hDEAD_BEEF;
          if (core5_q.size() < 16) begin
            wr_valid_i[5]         = 1'b1;
            wr_addr_i[5*AW +: AW] = AW'(10 + core5_q.size());
            wr_data_i[5*DW +: DW] = DW'(32'h500 + core5_q.size());
            core5_q.push_back({AW'(10 + core5_q.size()), DW'(32'h500 + core5_q.size())});
          end
        end
      end else begin
        rep_ready_i = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      tick();
      wr_valid_i = '0;
      cyc++;
      if (hs) idx++;
    end
    rep_ready_i = 1'b0;
    chk("drain_count", 64'(idx), 64'(n));
    chk("rec_done", 64'(rec_done_o), 64'(1) << core);
  endtask

  initial begin
    int w;
    rst_i       = 1'b1;
    wr_valid_i  = '0;
    wr_addr_i   = '0;
    wr_data_i   = '0;
    ckpt_i      = '0;
    rec_req_i   = '0;
    rep_ready_i = 1'b0;
    tick();
    tick();
    outputs_zero("reset");
    rst_i = 1'b0;
    tick();

    // Core 2: three writes, replayed in order with ready held high.
    log_write(2, 1, 32'hA, 1'b0);
    log_write(2, 2, 32'hB, 1'b0);
    log_write(2, 3, 32'hC, 1'b0);
    request(8'h04);
    chk("lat_cycle1_valid", 64'(rep_valid_o), 64'(0));
    tick();
    chk("lat_cycle2_valid", 64'(rep_valid_o), 64'(1));
    chk("lat_cycle2_busy",  64'(rec_busy_o),  64'(1));
    exp_q = {};
    exp_q.push_back({5'd1, 32'hA});
    exp_q.push_back({5'd2, 32'hB});
    exp_q.push_back({5'd3, 32'hC});
    drain(2, 1'b0, 1'b0);
    tick();
    chk("core2_idle_busy", 64'(rec_busy_o), 64'(0));

    // Core 0: 20 writes into a 16-deep log, oldest four lost.
    for (int i = 0; i < 20; i++) log_write(0, i % 32, i, 1'b0);
    chk("core0_overflow", 64'(overflow_o), 64'h01);
    request(8'h01);
    exp_q = {};
    for (int i = 4; i < 20; i++) exp_q.push_back({AW'(i), DW'(i)});
    drain(0, 1'b1, 1'b0);
    tick();
    chk("core0_overflow_cleared", 64'(overflow_o), 64'h00);

    // Core 1: checkpoint and write in the same cycle keep only the new write.
    log_write(1, 1, 32'h11, 1'b0);
    log_write(1, 2, 32'h12, 1'b0);
    log_write(1, 3, 32'h13, 1'b0);
    log_write(1, 5, 32'h55, 1'b1);
    request(8'h02);
    exp_q = {};
    exp_q.push_back({5'd5, 32'h55});
    drain(1, 1'b1, 1'b0);
    tick();

    // Simultaneous requests: lowest core first.
    log_write(1, 7, 32'h71, 1'b0);
    log_write(1, 8, 32'h72, 1'b0);
    log_write(3, 9, 32'h93, 1'b0);
    log_write(3, 10, 32'h94, 1'b0);
    request(8'h0A);
    exp_q = {};
    exp_q.push_back({5'd7, 32'h71});
    exp_q.push_back({5'd8, 32'h72});
    drain(1, 1'b0, 1'b0);
    exp_q = {};
    exp_q.push_back({5'd9,  32'h93});
    exp_q.push_back({5'd10, 32'h94});
    drain(3, 1'b1, 1'b0);
    tick();

    // Full core 4 log replayed under backpressure while core 4 is hammered and core 5 logs.
    for (int i = 0; i < 16; i++) log_write(4, i, 32'h400 + i, 1'b0);
    chk("core4_full_no_overflow", 64'(overflow_o), 64'h00);
    request(8'h10);
    exp_q = {};
    for (int i = 0; i < 16; i++) exp_q.push_back({AW'(i), DW'(32'h400 + i)});
    core5_q = {};
    drain(4, 1'b1, 1'b1);
    tick();
    chk("core5_logged_some", 64'(core5_q.size() >= 16), 64'(1));
    request(8'h10);
    chk("core4_empty_c1_valid", 64'(rep_valid_o), 64'(0));
    tick();
    chk("core4_empty_c2_valid", 64'(rep_valid_o), 64'(0));
    chk("core4_empty_c2_done",  64'(rec_done_o),  64'h10);
    tick();
    chk("core5_overflow", 64'(overflow_o), 64'h00);
    request(8'h20);
    exp_q = core5_q;
    drain(5, 1'b1, 1'b0);
    tick();

    // Reset in the middle of a replay.
    for (int i = 0; i < 17; i++) log_write(7, i, 32'h700 + i, 1'b0);
    chk("core7_overflow", 64'(overflow_o), 64'h80);
    log_write(6, 1, 32'h61, 1'b0);
    log_write(6, 2, 32'h62, 1'b0);
    log_write(6, 3, 32'h63, 1'b0);
    request(8'h40);
    w = 0;
    while (!rep_valid_o && w < 10) begin
      tick();
      w++;
    end
    chk("rst_pre_valid", 64'(rep_valid_o), 64'(1));
    rst_i = 1'b1;
    tick();
    outputs_zero("midrst");
    rst_i = 1'b0;
    tick();
    tick();
    chk("post_rst_nothing_pending", 64'(rec_busy_o), 64'(0));
    request(8'h40);
    chk("post_rst_c1_valid", 64'(rep_valid_o), 64'(0));
    tick();
    chk("post_rst_c2_valid", 64'(rep_valid_o), 64'(0));
    chk("post_rst_c2_done",  64'(rec_done_o),  64'h40);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
